fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_VECTOR_ADDR, default 16'h0000, meaning the instruction-memory word holding the start PC.
REQ-002 The block SHALL have parameter HLT_OPCODE, default 5'b00001, meaning the opcode in instruction[15:11] that halts fetch.
REQ-003 The block SHALL have port clk  input  1  meaning the single system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  meaning the asynchronous, active-low reset (0 = reset asserted).
REQ-005 The block SHALL have port imem_addr  output  16  meaning the instruction-memory word address.
REQ-006 The block SHALL have port imem_data  input  16  meaning the memory word at imem_addr, valid in the same cycle (combinational read).
REQ-007 The block SHALL have port stall  input  1  meaning hold PC and IF/ID contents.
REQ-008 The block SHALL have port flush  input  1  meaning replace the IF/ID contents with a NOP.
REQ-009 The block SHALL have port jump_taken  input  1  meaning redirect fetch to jump_target.
REQ-010 The block SHALL have port jump_target  input  16  meaning the redirect PC.
REQ-011 The block SHALL have port instruction  output  16  meaning the IF/ID instruction register feeding the decode stage.
REQ-012 The block SHALL have port pc_out  output  16  meaning the PC of the held instruction.
REQ-013 The block SHALL have port pc_next_out  output  16  meaning pc_out+1 of the held instruction, used as the CALL return address.
REQ-014 The block SHALL have port valid  output  1  meaning instruction is a real fetched instruction and not an inserted NOP.
REQ-015 The block SHALL have port halted  output  1  meaning fetch is stopped on HLT.

Function
REQ-016 The block SHALL implement a three-state FSM: BOOT, RUN, HALTED.
REQ-017 In BOOT, the block SHALL drive imem_addr=RESET_VECTOR_ADDR, load PC<=imem_data, keep IF/ID at NOP with valid=0, and go to RUN after exactly one cycle, ignoring all other inputs.
REQ-018 In RUN, the block SHALL drive imem_addr=PC.
REQ-019 Per-cycle priority in RUN SHALL be: jump_taken > flush > stall > normal.
REQ-020 On jump_taken, the block SHALL set PC<=jump_target and IF/ID<=NOP (instruction=16'h0000, valid=0); the fetched word is discarded.
REQ-021 On flush without jump_taken, the block SHALL set IF/ID<=NOP with valid=0 and leave PC unchanged, so the same address is refetched next cycle.
REQ-022 On stall alone, the block SHALL hold PC, instruction, pc_out, pc_next_out and valid unchanged.
REQ-023 In the normal case, the block SHALL set IF/ID<={imem_data, PC, PC+1}, valid<=1 and PC<=PC+1.
REQ-024 PC arithmetic SHALL be 16-bit modulo: 16'hFFFF+1 = 16'h0000, applied to both PC and pc_next_out.
REQ-025 In the normal case, when imem_data[15:11]==HLT_OPCODE, the block SHALL latch the HLT into IF/ID (valid=1), hold PC at the HLT address and go to HALTED.
REQ-026 If HLT is fetched in the same cycle as stall, flush or jump_taken, that signal's rule SHALL apply and the FSM SHALL stay in RUN.
REQ-027 In HALTED, the block SHALL load IF/ID<=NOP with valid=0 each cycle, assert halted=1, hold PC, and drive imem_addr=PC.
REQ-028 In HALTED, the block SHALL ignore stall and flush.
REQ-029 In HALTED, jump_taken SHALL set PC<=jump_target, deassert halted and return to RUN; IF/ID stays NOP for that cycle.
REQ-030 halted SHALL be a registered output, 1 only in HALTED.

Reset
REQ-031 While reset=0, the block SHALL asynchronously force state=BOOT, PC=16'h0000, instruction=16'h0000, pc_out=16'h0000, pc_next_out=16'h0001, valid=0 and halted=0.
REQ-032 Reset asserted mid-operation, including in HALTED or during stall, SHALL abort immediately with no partial update surviving.
REQ-033 After reset release, the first rising edge SHALL perform the BOOT vector load.
REQ-034 The first real instruction SHALL appear on instruction with valid=1 two rising edges after reset release.

Verification
REQ-035 Boot: M[0]=16'h0010, M[16]=16'h1234, M[17]=16'h2345, release reset -> edge 1: PC=16'h0010; edge 2: instruction=16'h1234, pc_out=16'h0010, pc_next_out=16'h0011, valid=1.
REQ-036 Stall: hold stall=1 for 3 cycles mid-stream -> instruction, pc_out and valid constant for 3 edges, and imem_addr constant; on release the next sequential word is delivered.
REQ-037 Jump vs stall: jump_taken=1, jump_target=16'h0040 and stall=1 in the same cycle -> instruction=16'h0000, valid=0, then M[0x40] delivered with pc_out=16'h0040.
REQ-038 Halt: M[0x20]={HLT_OPCODE,11'h0} -> HLT delivered with valid=1, then halted=1, valid=0 and PC=16'h0020 held for 10+ cycles; jump_taken to 16'h0050 -> halted=0 and M[0x50] delivered next.
REQ-039 Wrap: PC=16'hFFFF in the normal case -> pc_out=16'hFFFF, pc_next_out=16'h0000, next imem_addr=16'h0000.
REQ-040 Async reset: assert reset=0 between clock edges while in HALTED -> all outputs take their reset values before the next edge; after release, the BOOT load repeats.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Bundles the fetch stage's memory, pipeline-control and IF/ID signals.
// The master side is the fetch stage; the slave side is memory plus downstream pipeline.
interface fetch_stage_if;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        stall;
    logic        flush;
    logic        jump_taken;
    logic [15:0] jump_target;
    logic [15:0] instruction;
    logic [15:0] pc_out;
    logic [15:0] pc_next_out;
    logic        valid;
    logic        halted;

    modport master (
        output imem_addr, instruction, pc_out, pc_next_out, valid, halted,
        input  imem_data, stall, flush, jump_taken, jump_target
    );

    modport slave (
        input  imem_addr, instruction, pc_out, pc_next_out, valid, halted,
        output imem_data, stall, flush, jump_taken, jump_target
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: loads the start PC from a boot vector, then fills the
// IF/ID register under jump/flush/stall control and stops on HLT until redirected.
module fetch_stage #(
    parameter logic [15:0] RESET_VECTOR_ADDR = 16'h0000,
    parameter logic [4:0]  HLT_OPCODE        = 5'b00001
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);
    typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALTED} state_t;

    state_t      r_state, w_state_next;
    logic [15:0] r_pc, w_pc_next;
    logic [15:0] r_instr, w_instr_next;
    logic [15:0] r_pc_out, w_pc_out_next;
    logic [15:0] r_pc_nxt, w_pc_nxt_next;
    logic        r_valid, w_valid_next;
    logic        r_halted;
    logic        w_is_hlt;
    logic [15:0] w_pc_inc;

    assign w_is_hlt = (bus.imem_data[15:11] == HLT_OPCODE);
    assign w_pc_inc = r_pc + 16'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_BOOT;
            r_pc     <= 16'h0000;
            r_instr  <= 16'h0000;
            r_pc_out <= 16'h0000;
            r_pc_nxt <= 16'h0001;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_pc     <= w_pc_next;
            r_instr  <= w_instr_next;
            r_pc_out <= w_pc_out_next;
            r_pc_nxt <= w_pc_nxt_next;
            r_valid  <= w_valid_next;
            r_halted <= (w_state_next == S_HALTED);
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_pc_next     = r_pc;
        w_instr_next  = r_instr;
        w_pc_out_next = r_pc_out;
        w_pc_nxt_next = r_pc_nxt;
        w_valid_next  = r_valid;
        case (r_state)
            S_BOOT: begin
                w_pc_next    = bus.imem_data;
                w_instr_next = 16'h0000;
                w_valid_next = 1'b0;
                w_state_next = S_RUN;
            end
            S_RUN: begin
                if (bus.jump_taken) begin
                    w_pc_next    = bus.jump_target;
                    w_instr_next = 16'h0000;
                    w_valid_next = 1'b0;
                end else if (bus.flush) begin
                    w_instr_next = 16'h0000;
                    w_valid_next = 1'b0;
                end else if (!bus.stall) begin
                    w_instr_next  = bus.imem_data;
                    w_pc_out_next = r_pc;
                    w_pc_nxt_next = w_pc_inc;
                    w_valid_next  = 1'b1;
                    // HLT parks the PC on its own address so a resume refetches nothing stale
                    if (w_is_hlt) begin
                        w_state_next = S_HALTED;
                    end else begin
                        w_pc_next = w_pc_inc;
                    end
                end
            end
            S_HALTED: begin
                w_instr_next = 16'h0000;
                w_valid_next = 1'b0;
                if (bus.jump_taken) begin
                    w_pc_next    = bus.jump_target;
                    w_state_next = S_RUN;
                end
            end
            default: w_state_next = S_BOOT;
        endcase
    end

    assign bus.imem_addr   = (r_state == S_BOOT) ? RESET_VECTOR_ADDR : r_pc;
    assign bus.instruction = r_instr;
    assign bus.pc_out      = r_pc_out;
    assign bus.pc_next_out = r_pc_nxt;
    assign bus.valid       = r_valid;
    assign bus.halted      = r_halted;
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized control
// traffic compared against a cycle-level behavioural model of the fetch rules.
module tb_fetch_stage;
    localparam logic [15:0] RV  = 16'h0000;
    localparam logic [4:0]  HLT = 5'b00001;

    logic clk;
    logic reset;
    fetch_stage_if bus();
    logic [15:0] mem [0:65535];

    int errors = 0;
    int checks = 0;

    // behavioural model state
    bit          m_boot, m_halt, m_valid;
    logic [15:0] m_pc, m_instr, m_pco, m_pcn;

    fetch_stage #(.RESET_VECTOR_ADDR(RV), .HLT_OPCODE(HLT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.imem_data = mem[bus.imem_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        m_boot = 1; m_halt = 0; m_valid = 0;
        m_pc = 16'h0000; m_instr = 16'h0000; m_pco = 16'h0000; m_pcn = 16'h0001;
    endtask

    task automatic model_edge(input bit st, input bit fl, input bit jt, input logic [15:0] tgt);
        logic [15:0] w;
        if (m_boot) begin
            m_pc = mem[RV]; m_boot = 0; m_instr = 16'h0000; m_valid = 0;
        end else if (m_halt) begin
            m_instr = 16'h0000; m_valid = 0;
            if (jt) begin m_pc = tgt; m_halt = 0; end
        end else if (jt) begin
            m_pc = tgt; m_instr = 16'h0000; m_valid = 0;
        end else if (fl) begin
            m_instr = 16'h0000; m_valid = 0;
        end else if (!st) begin
            w = mem[m_pc];
            m_instr = w; m_pco = m_pc; m_pcn = m_pc + 16'd1; m_valid = 1;
            if (w[15:11] == HLT) m_halt = 1;
            else m_pc = m_pc + 16'd1;
        end
    endtask

    // apply inputs, take one rising edge, settle
    task automatic tick(input bit st, input bit fl, input bit jt, input logic [15:0] tgt);
        bus.stall = st; bus.flush = fl; bus.jump_taken = jt; bus.jump_target = tgt;
        @(posedge clk);
        model_edge(st, fl, jt, tgt);
        #1;
        bus.stall = 0; bus.flush = 0; bus.jump_taken = 0; bus.jump_target = 16'h0000;
    endtask

    task automatic assert_reset();
        reset = 1'b0;
        bus.stall = 0; bus.flush = 0; bus.jump_taken = 0; bus.jump_target = 16'h0000;
        model_reset();
        #7;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.stall = 0; bus.flush = 0; bus.jump_taken = 0; bus.jump_target = 16'h0000;
        model_reset();
        #12;
        checks++; if (bus.instruction !== 16'h0000) begin errors++; $display("FAIL rst_instr got=%h exp=0000", bus.instruction); end
        checks++; if (bus.pc_out !== 16'h0000) begin errors++; $display("FAIL rst_pc_out got=%h exp=0000", bus.pc_out); end
        checks++; if (bus.pc_next_out !== 16'h0001) begin errors++; $display("FAIL rst_pc_next got=%h exp=0001", bus.pc_next_out); end
        checks++; if (bus.valid !== 1'b0 || bus.halted !== 1'b0) begin errors++; $display("FAIL rst_flags got valid=%b halted=%b exp=0/0", bus.valid, bus.halted); end
        checks++; if (bus.imem_addr !== RV) begin errors++; $display("FAIL rst_imem_addr got=%h exp=%h", bus.imem_addr, RV); end
        @(negedge clk);
        reset = 1'b1;
        $display("reset: outputs at reset values");
    endtask

    task automatic test_boot();
        tick(0, 0, 0, 0);
        checks++; if (bus.imem_addr !== 16'h0010 || bus.valid !== 1'b0) begin errors++; $display("FAIL boot_edge1 got addr=%h valid=%b exp=0010/0", bus.imem_addr, bus.valid); end
        tick(0, 0, 0, 0);
        checks++; if (bus.instruction !== 16'h1234 || bus.valid !== 1'b1) begin errors++; $display("FAIL boot_instr got=%h/%b exp=1234/1", bus.instruction, bus.valid); end
        checks++; if (bus.pc_out !== 16'h0010 || bus.pc_next_out !== 16'h0011) begin errors++; $display("FAIL boot_pc got=%h/%h exp=0010/0011", bus.pc_out, bus.pc_next_out); end
        $display("boot: first instruction %h at pc %h", bus.instruction, bus.pc_out);
    endtask

    task automatic test_stall();
        tick(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick(1, 0, 0, 0);
            checks++;
            if (bus.instruction !== 16'h2345 || bus.pc_out !== 16'h0011 || bus.valid !== 1'b1 || bus.imem_addr !== 16'h0012) begin
                errors++; $display("FAIL stall_hold%0d got instr=%h pc=%h v=%b addr=%h exp=2345/0011/1/0012", i, bus.instruction, bus.pc_out, bus.valid, bus.imem_addr);
            end
        end
        tick(0, 0, 0, 0);
        checks++; if (bus.instruction !== 16'h3456 || bus.pc_out !== 16'h0012) begin errors++; $display("FAIL stall_release got=%h/%h exp=3456/0012", bus.instruction, bus.pc_out); end
        $display("stall: held 3 cycles, resumed with %h", bus.instruction);
    endtask

    task automatic test_jump_vs_stall();
        tick(1, 0, 1, 16'h0040);
        checks++; if (bus.instruction !== 16'h0000 || bus.valid !== 1'b0 || bus.imem_addr !== 16'h0040) begin errors++; $display("FAIL jump_nop got=%h/%b/%h exp=0000/0/0040", bus.instruction, bus.valid, bus.imem_addr); end
        tick(0, 0, 0, 0);
        checks++; if (bus.instruction !== 16'h5A5A || bus.pc_out !== 16'h0040 || bus.pc_next_out !== 16'h0041) begin errors++; $display("FAIL jump_target got=%h/%h/%h exp=5a5a/0040/0041", bus.instruction, bus.pc_out, bus.pc_next_out); end
        tick(0, 1, 0, 0);
        checks++; if (bus.valid !== 1'b0 || bus.instruction !== 16'h0000 || bus.imem_addr !== 16'h0041) begin errors++; $display("FAIL flush_nop got=%h/%b/%h exp=0000/0/0041", bus.instruction, bus.valid, bus.imem_addr); end
        tick(0, 0, 0, 0);
        checks++; if (bus.instruction !== 16'h6B6B || bus.pc_out !== 16'h0041) begin errors++; $display("FAIL flush_refetch got=%h/%h exp=6b6b/0041", bus.instruction, bus.pc_out); end
        $display("jump/flush: redirect to 0040 and refetch of 0041 done");
    endtask

    task automatic test_halt();
        tick(0, 0, 1, 16'h0020);
        tick(0, 1, 0, 0);
        checks++; if (bus.halted !== 1'b0 || bus.valid !== 1'b0 || bus.imem_addr !== 16'h0020) begin errors++; $display("FAIL hlt_flush got halted=%b v=%b addr=%h exp=0/0/0020", bus.halted, bus.valid, bus.imem_addr); end
        tick(0, 0, 0, 0);
        checks++; if (bus.instruction !== 16'h0800 || bus.valid !== 1'b1 || bus.pc_out !== 16'h0020) begin errors++; $display("FAIL hlt_deliver got=%h/%b/%h exp=0800/1/0020", bus.instruction, bus.valid, bus.pc_out); end
        for (int i = 0; i < 12; i++) begin
            tick(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 0, 0);
            checks++;
            if (bus.halted !== 1'b1 || bus.valid !== 1'b0 || bus.instruction !== 16'h0000 || bus.imem_addr !== 16'h0020) begin
                errors++; $display("FAIL hlt_hold%0d got h=%b v=%b instr=%h addr=%h exp=1/0/0000/0020", i, bus.halted, bus.valid, bus.instruction, bus.imem_addr);
            end
        end
        tick(0, 0, 1, 16'h0050);
        checks++; if (bus.halted !== 1'b0 || bus.valid !== 1'b0 || bus.imem_addr !== 16'h0050) begin errors++; $display("FAIL hlt_resume got h=%b v=%b addr=%h exp=0/0/0050", bus.halted, bus.valid, bus.imem_addr); end
        tick(0, 0, 0, 0);
        checks++; if (bus.instruction !== 16'h7C7C || bus.pc_out !== 16'h0050 || bus.valid !== 1'b1) begin errors++; $display("FAIL hlt_next got=%h/%h/%b exp=7c7c/0050/1", bus.instruction, bus.pc_out, bus.valid); end
        $display("halt: held at 0020, resumed at 0050");
    endtask

    task automatic test_wrap();
        tick(0, 0, 1, 16'hFFFF);
        tick(0, 0, 0, 0);
        checks++; if (bus.pc_out !== 16'hFFFF || bus.pc_next_out !== 16'h0000 || bus.imem_addr !== 16'h0000) begin errors++; $display("FAIL wrap got pc=%h nxt=%h addr=%h exp=ffff/0000/0000", bus.pc_out, bus.pc_next_out, bus.imem_addr); end
        tick(0, 0, 0, 0);
        checks++; if (bus.instruction !== 16'h0010 || bus.pc_out !== 16'h0000) begin errors++; $display("FAIL wrap_next got=%h/%h exp=0010/0000", bus.instruction, bus.pc_out); end
        $display("wrap: ffff -> 0000");
    endtask

    task automatic test_async_reset();
        tick(0, 0, 1, 16'h0020);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL areset_pre got halted=%b exp=1", bus.halted); end
        #2 reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bus.instruction !== 16'h0000 || bus.pc_out !== 16'h0000 || bus.pc_next_out !== 16'h0001 || bus.valid !== 1'b0 || bus.halted !== 1'b0 || bus.imem_addr !== RV) begin
            errors++; $display("FAIL areset_now got instr=%h pc=%h nxt=%h v=%b h=%b addr=%h", bus.instruction, bus.pc_out, bus.pc_next_out, bus.valid, bus.halted, bus.imem_addr);
        end
        @(negedge clk);
        reset = 1'b1;
        tick(0, 0, 0, 0);
        checks++; if (bus.imem_addr !== 16'h0010) begin errors++; $display("FAIL areset_boot got addr=%h exp=0010", bus.imem_addr); end
        tick(0, 0, 0, 0);
        checks++; if (bus.instruction !== 16'h1234 || bus.valid !== 1'b1) begin errors++; $display("FAIL areset_first got=%h/%b exp=1234/1", bus.instruction, bus.valid); end
        $display("async reset: cleared mid-halt, boot repeated");
    endtask

    task automatic test_random();
        int n_err_start;
        n_err_start = errors;
        for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
        mem[RV] = 16'($urandom_range(0, 255));
        assert_reset();
        for (int i = 0; i < 3000; i++) begin
            bit st, fl, jt;
            logic [15:0] tgt;
            st  = ($urandom_range(0, 3) == 0);
            fl  = ($urandom_range(0, 7) == 0);
            jt  = ($urandom_range(0, 15) == 0);
            tgt = 16'($urandom);
            tick(st, fl, jt, tgt);
            checks++;
            if (bus.imem_addr !== (m_boot ? RV : m_pc) || bus.instruction !== m_instr || bus.valid !== m_valid || bus.halted !== m_halt) begin
                errors++;
                $display("FAIL rand%0d got addr=%h instr=%h v=%b h=%b exp=%h/%h/%b/%b", i, bus.imem_addr, bus.instruction, bus.valid, bus.halted, (m_boot ? RV : m_pc), m_instr, m_valid, m_halt);
            end
            if (m_valid) begin
                checks++;
                if (bus.pc_out !== m_pco || bus.pc_next_out !== m_pcn) begin
                    errors++; $display("FAIL rand_pc%0d got=%h/%h exp=%h/%h", i, bus.pc_out, bus.pc_next_out, m_pco, m_pcn);
                end
            end
        end
        $display("random: 3000 cycles, %0d new errors", errors - n_err_start);
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
        mem[16'h0000] = 16'h0010;
        mem[16'h0010] = 16'h1234;
        mem[16'h0011] = 16'h2345;
        mem[16'h0012] = 16'h3456;
        mem[16'h0013] = 16'h4567;
        mem[16'h0020] = {HLT, 11'h000};
        mem[16'h0040] = 16'h5A5A;
        mem[16'h0041] = 16'h6B6B;
        mem[16'h0050] = 16'h7C7C;
        mem[16'hFFFF] = 16'h1111;
        test_reset();
        test_boot();
        test_stall();
        test_jump_vs_stall();
        test_halt();
        test_wrap();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
